// File: rtl/addr_gen_if.sv
// Bus between the control unit and the address-generation unit. The control
// unit drives the op request; the unit returns addresses, PC/SP and status.
interface addr_gen_if #(
    parameter int ADDR_W = 16
);
    // Handshake: start is a request that is taken only in a cycle where busy=0
    // (a request seen while busy=1 is dropped, not queued); each accepted op
    // ends with exactly one done pulse, the cycle address holds its result.
    logic              start;
    logic [2:0]        mode;
    logic [7:0]        operand_lo;
    logic [ADDR_W-9:0] operand_hi;
    logic [7:0]        index;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W-1:0] pc_out;
    logic [7:0]        sp_out;
    logic              busy;
    logic              done;
    logic              page_cross;
    logic              state_dbg;

    modport master (
        output start, mode, operand_lo, operand_hi, index,
        input  address, pc_out, sp_out, busy, done, page_cross, state_dbg
    );

    modport slave (
        input  start, mode, operand_lo, operand_hi, index,
        output address, pc_out, sp_out, busy, done, page_cross, state_dbg
    );
endinterface

// File: rtl/addr_gen_unit.sv
// Address-generation unit: owns PC and SP and produces sequential, jump,
// branch, indexed, zero-page and stack addresses with a page-cross fix-up cycle.
module addr_gen_unit #(
    parameter int          ADDR_W       = 16,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_FFFC,
    parameter logic [7:0]  SP_RESET     = 8'hFF,
    parameter logic [7:0]  STACK_PAGE   = 8'h01
) (
    input  logic      clk,
    input  logic      rst,
    addr_gen_if.slave bus
);
    localparam logic [ADDR_W-1:0] RV     = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-9:0] STK_HI = (ADDR_W-8)'(STACK_PAGE);

    localparam logic [2:0] M_INC    = 3'd0;
    localparam logic [2:0] M_JUMP   = 3'd1;
    localparam logic [2:0] M_BRANCH = 3'd2;
    localparam logic [2:0] M_IDX    = 3'd3;
    localparam logic [2:0] M_PUSH   = 3'd4;
    localparam logic [2:0] M_PULL   = 3'd5;
    localparam logic [2:0] M_ZPIDX  = 3'd6;

    typedef enum logic {IDLE = 1'b0, FIX = 1'b1} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        sp_q, sp_n;
    logic              done_q, done_n;
    logic              cross_q, cross_n;
    // Corrected address and whether it also becomes the PC, held across FIX.
    logic [ADDR_W-1:0] fix_addr_q, fix_addr_n;
    logic              fix_pc_q, fix_pc_n;

    logic [8:0]        sum9;
    logic [ADDR_W-1:0] br_target;

    assign sum9      = {1'b0, bus.operand_lo} + {1'b0, bus.index};
    assign br_target = pc_q + {{(ADDR_W-8){bus.operand_lo[7]}}, bus.operand_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc_q       <= RV;
            addr_q     <= RV;
            sp_q       <= SP_RESET;
            done_q     <= 1'b0;
            cross_q    <= 1'b0;
            fix_addr_q <= RV;
            fix_pc_q   <= 1'b0;
        end else begin
            state      <= state_n;
            pc_q       <= pc_n;
            addr_q     <= addr_n;
            sp_q       <= sp_n;
            done_q     <= done_n;
            cross_q    <= cross_n;
            fix_addr_q <= fix_addr_n;
            fix_pc_q   <= fix_pc_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc_q;
        addr_n     = addr_q;
        sp_n       = sp_q;
        done_n     = 1'b0;
        cross_n    = 1'b0;
        fix_addr_n = fix_addr_q;
        fix_pc_n   = fix_pc_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    done_n = 1'b1;
                    case (bus.mode)
                        M_INC: begin
                            pc_n   = pc_q + ADDR_W'(1);
                            addr_n = pc_q + ADDR_W'(1);
                        end
                        M_JUMP: begin
                            pc_n   = {bus.operand_hi, bus.operand_lo};
                            addr_n = {bus.operand_hi, bus.operand_lo};
                        end
                        M_BRANCH: begin
                            if (br_target[ADDR_W-1:8] == pc_q[ADDR_W-1:8]) begin
                                pc_n   = br_target;
                                addr_n = br_target;
                            end else begin
                                // PC stays put until the corrected target lands in FIX.
                                addr_n     = {pc_q[ADDR_W-1:8], br_target[7:0]};
                                fix_addr_n = br_target;
                                fix_pc_n   = 1'b1;
                                done_n     = 1'b0;
                                state_n    = FIX;
                            end
                        end
                        M_IDX: begin
                            addr_n = {bus.operand_hi, sum9[7:0]};
                            if (sum9[8]) begin
                                fix_addr_n = {bus.operand_hi + (ADDR_W-8)'(1), sum9[7:0]};
                                fix_pc_n   = 1'b0;
                                done_n     = 1'b0;
                                state_n    = FIX;
                            end
                        end
                        M_PUSH: begin
                            addr_n = {STK_HI, sp_q};
                            sp_n   = sp_q - 8'd1;
                        end
                        M_PULL: begin
                            addr_n = {STK_HI, sp_q + 8'd1};
                            sp_n   = sp_q + 8'd1;
                        end
                        M_ZPIDX: begin
                            addr_n = {{(ADDR_W-8){1'b0}}, sum9[7:0]};
                        end
                        default: ;
                    endcase
                end
            end
            FIX: begin
                addr_n  = fix_addr_q;
                if (fix_pc_q) pc_n = fix_addr_q;
                done_n  = 1'b1;
                cross_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.address    = addr_q;
    assign bus.pc_out     = pc_q;
    assign bus.sp_out     = sp_q;
    assign bus.busy       = (state == FIX);
    assign bus.done       = done_q;
    assign bus.page_cross = cross_q;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_addr_gen_unit.sv
// Bench for addr_gen_unit (ADDR_W=16): op-level model with expected queue,
// per-cycle compare after each rising edge, and literal checks on known cases.
module tb_addr_gen_unit;
    localparam int AW = 16;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] pc;
        logic [7:0]  sp;
        logic        busy;
        logic        done;
        logic        pcross;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic clk;
    logic rst;
    addr_gen_if #(.ADDR_W(AW)) bus();

    addr_gen_unit #(.ADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [15:0] m_addr, m_pc;
    logic [7:0]  m_sp;
    bit          m_cross;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (act=timeout req=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: act=%0h req=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 16'hFFFC;
        m_pc   = 16'hFFFC;
        m_sp   = 8'hFF;
    endtask

    // Op-level model: works out the result from the architectural rules and
    // queues one expected snapshot per cycle the op occupies.
    task automatic model_op(input logic [2:0] mode, input logic [7:0] lo,
                            input logic [7:0] hi, input logic [7:0] idx);
        int offset, sum, t;
        logic [15:0] first;
        exp_t e;
        m_cross = 0;
        first   = 16'h0;
        case (mode)
            3'd0: begin m_pc = 16'((int'(m_pc) + 1) % 65536); m_addr = m_pc; end
            3'd1: begin m_pc = 16'(int'(hi) * 256 + int'(lo)); m_addr = m_pc; end
            3'd2: begin
                offset = (lo < 128) ? int'(lo) : int'(lo) - 256;
                t = (int'(m_pc) + offset + 65536) % 65536;
                if (t / 256 != int'(m_pc) / 256) begin
                    m_cross = 1;
                    first = 16'((int'(m_pc) / 256) * 256 + t % 256);
                end
            end
            3'd3: begin
                sum = int'(lo) + int'(idx);
                t = (int'(hi) * 256 + sum) % 65536;
                if (sum > 255) begin
                    m_cross = 1;
                    first = 16'(int'(hi) * 256 + sum % 256);
                end
            end
            3'd4: begin m_addr = 16'(256 + int'(m_sp)); m_sp = 8'((int'(m_sp) + 255) % 256); end
            3'd5: begin m_sp = 8'((int'(m_sp) + 1) % 256); m_addr = 16'(256 + int'(m_sp)); end
            3'd6: m_addr = 16'((int'(lo) + int'(idx)) % 256);
            default: ;
        endcase
        if (m_cross) begin
            e = '{addr: first, pc: m_pc, sp: m_sp, busy: 1'b1, done: 1'b0, pcross: 1'b0};
            exp_q.push_back(EXP_W'(e));
        end
        if (mode == 3'd2) begin m_pc = 16'(t); m_addr = 16'(t); end
        if (mode == 3'd3) m_addr = 16'(t);
        e = '{addr: m_addr, pc: m_pc, sp: m_sp, busy: 1'b0, done: 1'b1, pcross: 1'(m_cross)};
        exp_q.push_back(EXP_W'(e));
    endtask

    // ---------------- driver ----------------
    task automatic op(input logic [2:0] mode, input logic [7:0] lo, input logic [7:0] hi,
                      input logic [7:0] idx, output logic [15:0] first_addr,
                      output logic first_busy, output logic first_done);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = mode;
        bus.operand_lo = lo; bus.operand_hi = hi; bus.index = idx;
        model_op(mode, lo, hi, idx);
        @(negedge clk);
        first_addr = bus.address; first_busy = bus.busy; first_done = bus.done;
        bus.start = 1'b0;
        if (m_cross) @(negedge clk);
    endtask

    // ---------------- scoreboard compare ----------------
    always begin
        exp_t cur;
        @(posedge clk);
        #1;
        if (check_en) begin
            if (exp_q.size() > 0) cur = exp_t'(exp_q.pop_front());
            else cur = '{addr: m_addr, pc: m_pc, sp: m_sp, busy: 1'b0, done: 1'b0, pcross: 1'b0};
            check("cyc_address", 32'(bus.address), 32'(cur.addr));
            check("cyc_pc", 32'(bus.pc_out), 32'(cur.pc));
            check("cyc_sp", 32'(bus.sp_out), 32'(cur.sp));
            check("cyc_busy", 32'(bus.busy), 32'(cur.busy));
            check("cyc_done", 32'(bus.done), 32'(cur.done));
            check("cyc_page_cross", 32'(bus.page_cross), 32'(cur.pcross));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [15:0] fa;
        logic fb, fd;
        logic [15:0] pc_before;
        exp_t e;
        rst = 1'b1;
        bus.start = 1'b0; bus.mode = 3'd7;
        bus.operand_lo = 8'h00; bus.operand_hi = 8'h00; bus.index = 8'h00;
        repeat (3) @(negedge clk);
        model_reset();
        check("reset_pc", 32'(bus.pc_out), 32'h FFFC);
        check("reset_address", 32'(bus.address), 32'hFFFC);
        check("reset_sp", 32'(bus.sp_out), 32'hFF);
        check("reset_busy_done", 32'({bus.busy, bus.done, bus.page_cross}), 32'h0);
        check_en = 1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // INC wrap at all-ones
        op(3'd1, 8'hFF, 8'hFF, 8'h00, fa, fb, fd);
        op(3'd0, 8'h00, 8'h00, 8'h00, fa, fb, fd);
        check("inc_wrap_addr", 32'(fa), 32'h0000);
        check("inc_wrap_pc", 32'(bus.pc_out), 32'h0000);
        check("inc_wrap_done", 32'({fd, bus.page_cross}), 32'b10);

        // IDX with and without page cross
        op(3'd3, 8'hF0, 8'h12, 8'h20, fa, fb, fd);
        check("idx_cross_first", 32'({fa, fb, fd}), {14'h0, 16'h1210, 2'b10});
        check("idx_cross_final", 32'({bus.address, bus.done, bus.page_cross}), {14'h0, 16'h1310, 2'b11});
        op(3'd3, 8'hF0, 8'h12, 8'h0F, fa, fb, fd);
        check("idx_nocross", 32'({fa, fb, fd}), {14'h0, 16'h12FF, 2'b01});

        // BRANCH backward in-page, forward across page, backward across page
        op(3'd1, 8'h80, 8'h02, 8'h00, fa, fb, fd);
        op(3'd2, 8'h90, 8'h00, 8'h00, fa, fb, fd);
        check("branch_back_addr", 32'({fa, fd}), {15'h0, 16'h0210, 1'b1});
        check("branch_back_pc", 32'(bus.pc_out), 32'h0210);
        op(3'd1, 8'hF0, 8'h02, 8'h00, fa, fb, fd);
        op(3'd2, 8'h7F, 8'h00, 8'h00, fa, fb, fd);
        check("branch_cross_first", 32'({fa, fb}), {15'h0, 16'h026F, 1'b1});
        check("branch_cross_final", 32'({bus.address, bus.pc_out, bus.page_cross}), {7'h0, 16'h036F, 16'h036F, 1'b1});
        op(3'd2, 8'h80, 8'h00, 8'h00, fa, fb, fd);

        // Stack wrap around sp=00 and zero-page index
        op(3'd5, 8'h00, 8'h00, 8'h00, fa, fb, fd);
        check("pull_to_00", 32'({bus.address, bus.sp_out}), {8'h0, 16'h0100, 8'h00});
        op(3'd4, 8'h00, 8'h00, 8'h00, fa, fb, fd);
        check("push_at_00", 32'({bus.address, bus.sp_out}), {8'h0, 16'h0100, 8'hFF});
        op(3'd5, 8'h00, 8'h00, 8'h00, fa, fb, fd);
        check("pull_at_ff", 32'({bus.address, bus.sp_out}), {8'h0, 16'h0100, 8'h00});
        op(3'd6, 8'hF0, 8'h55, 8'h20, fa, fb, fd);
        check("zpidx_addr", 32'(bus.address), 32'h0010);
        op(3'd7, 8'h12, 8'h34, 8'h56, fa, fb, fd);
        check("nop_addr", 32'({bus.address, fd}), {15'h0, 16'h0010, 1'b1});

        // start while busy is dropped
        pc_before = m_pc;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd3;
        bus.operand_lo = 8'hC0; bus.operand_hi = 8'h40; bus.index = 8'h80;
        model_op(3'd3, 8'hC0, 8'h40, 8'h80);
        @(negedge clk);
        bus.mode = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_start_pc", 32'(bus.pc_out), 32'(pc_before));
        check("busy_start_final", 32'(bus.address), 32'h4140);
        repeat (2) @(negedge clk);

        // Reset during FIX aborts without done
        op(3'd1, 8'hF0, 8'h02, 8'h00, fa, fb, fd);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd2; bus.operand_lo = 8'h40;
        model_op(3'd2, 8'h40, 8'h00, 8'h00);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        e = '{addr: m_addr, pc: m_pc, sp: m_sp, busy: 1'b0, done: 1'b0, pcross: 1'b0};
        exp_q.push_back(EXP_W'(e));
        @(negedge clk);
        rst = 1'b0;
        check("rst_fix_done", 32'({bus.done, bus.page_cross, bus.busy}), 32'h0);
        check("rst_fix_pc", 32'(bus.pc_out), 32'hFFFC);
        repeat (2) @(negedge clk);

        // Mixed sequence checked cycle by cycle against the model
        for (int i = 0; i < 24; i++) begin
            op(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), fa, fb, fd);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
